// File: rtl/shared_bus_pkg.sv
// rtl/shared_bus_pkg.sv - shared data bus constants, FSM encoding and grant helper
//
// Purpose: common definitions for the shared data-memory bus, used by the
// bus arbiter and by the slave-side memory controller.
//   NUM_CORES    number of cores on the bus (width of the one-hot grant)
//   CORE_BITS    width of a core index
//   ADDR_BITS    word-address width
//   bus_state_e  controller FSM encoding
//   onehot_valid true when a grant vector has exactly one bit set
package shared_bus_pkg;

  localparam int NUM_CORES = 4;
  localparam int CORE_BITS = $clog2(NUM_CORES);
  localparam int ADDR_BITS = 30;

  typedef logic [NUM_CORES-1:0] grant_t;
  typedef logic [CORE_BITS-1:0] core_idx_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } bus_state_e;

  function automatic logic onehot_valid(input grant_t g);
    int ones = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      ones += int'(g[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/llsc_reservation_table.sv
// rtl/llsc_reservation_table.sv - per-core load-linked/store-conditional reservation registers
//
// Purpose: one {valid, addr} reservation per core.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   set_en/core/addr       load-linked: core reserves addr (overwrites older one)
//   clear_en/clear_core    store-conditional: drop that core's reservation
//   snoop_en/snoop_addr    a RAM write happened: drop every reservation on addr
//   match_core/match_addr  lookup key
//   match                  combinational: reservation of match_core is valid on match_addr
module llsc_reservation_table
  import shared_bus_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      set_en,
  input  core_idx_t set_core,
  input  addr_t     set_addr,
  input  logic      clear_en,
  input  core_idx_t clear_core,
  input  logic      snoop_en,
  input  addr_t     snoop_addr,
  input  core_idx_t match_core,
  input  addr_t     match_addr,
  output logic      match
);

  logic [NUM_CORES-1:0] res_valid;
  addr_t                res_addr [NUM_CORES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        res_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        // Snoop is word granular: byte enables of the write do not matter.
        if ((snoop_en && (res_addr[i] == snoop_addr)) ||
            (clear_en && (clear_core == core_idx_t'(i)))) begin
          res_valid[i] <= 1'b0;
        end
        // A set is only ever issued for a read, so it never collides with a
        // snoop or clear in the same cycle; placing it last keeps it dominant.
        if (set_en && (set_core == core_idx_t'(i))) begin
          res_valid[i] <= 1'b1;
          res_addr[i]  <= set_addr;
        end
      end
    end
  end

  assign match = res_valid[match_core] && (res_addr[match_core] == match_addr);

endmodule

// File: rtl/shared_dmem_ctrl.sv
// rtl/shared_dmem_ctrl.sv - shared data memory bus slave: SRAM sequencer with wait states and LL/SC
//
// Purpose: accepts one transaction at a time from the granted core, strobes a
// single-port synchronous SRAM, waits WAIT_STATES cycles, returns data and the
// Ready handshake, and tracks LL/SC reservations per core.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   D_Bus_GRANT        one-hot grant from the arbiter (selects the core)
//   DataMem_Read       read strobe (only a solid 1 counts)
//   DataMem_Write      byte write enables (any 1 bit means write; write beats read)
//   DataMem_Address    word address
//   DataMem_Out        write data from the core
//   DataMem_LL/SC      load-linked / store-conditional qualifiers
//   DataMem_Ready      transaction complete; high only in DONE
//   DataMem_In         read data, held until the next read completes
//   SC_Success         1 only after a successful store-conditional
//   Ram_RE/Ram_WE      one-cycle SRAM strobes
//   Ram_Addr/Ram_WData SRAM address and write data
//   Ram_RData          SRAM read data, valid the cycle after Ram_RE
module shared_dmem_ctrl
  import shared_bus_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] D_Bus_GRANT,
  input  logic                 DataMem_Read,
  input  logic [3:0]           DataMem_Write,
  input  logic [ADDR_BITS-1:0] DataMem_Address,
  input  logic [31:0]          DataMem_Out,
  input  logic                 DataMem_LL,
  input  logic                 DataMem_SC,
  output logic                 DataMem_Ready,
  output logic [31:0]          DataMem_In,
  output logic                 SC_Success,
  output logic                 Ram_RE,
  output logic [3:0]           Ram_WE,
  output logic [ADDR_BITS-1:0] Ram_Addr,
  output logic [31:0]          Ram_WData,
  input  logic [31:0]          Ram_RData
);

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  function automatic core_idx_t grant_to_index(input grant_t g);
    core_idx_t idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (g[i]) idx = core_idx_t'(i);
    end
    return idx;
  endfunction

  bus_state_e state, state_next;
  logic [3:0] wait_cnt;
  logic       lat_read;
  logic       lat_sc_ok;

  logic       rd_req, wr_req, req_valid, accept;
  logic       is_read, is_ll, is_sc, sc_ok, do_write;
  core_idx_t  req_core;
  logic       res_match;

  // Request decode. The strobes are compared with === so that a floating or
  // unknown strobe from an idle core is never mistaken for a request.
  always_comb begin
    rd_req = (DataMem_Read === 1'b1);
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (DataMem_Write[i] === 1'b1) wr_req = 1'b1;
    end
    req_core  = grant_to_index(D_Bus_GRANT);
    is_read   = rd_req && !wr_req;
    // LL together with SC on a read degrades to a plain read.
    is_ll     = is_read && DataMem_LL && !DataMem_SC;
    is_sc     = wr_req && DataMem_SC;
    sc_ok     = is_sc && res_match;
    do_write  = wr_req && (!is_sc || sc_ok);
    req_valid = (rd_req || wr_req) && onehot_valid(D_Bus_GRANT);
    accept    = (state == ST_IDLE) && req_valid;
  end

  // Reservations are updated at acceptance, using the grant of that cycle;
  // later grant changes cannot affect the transaction in flight.
  llsc_reservation_table u_resv (
    .clock      (clock),
    .reset      (reset),
    .set_en     (accept && is_ll),
    .set_core   (req_core),
    .set_addr   (DataMem_Address),
    .clear_en   (accept && is_sc),
    .clear_core (req_core),
    .snoop_en   (accept && do_write),
    .snoop_addr (DataMem_Address),
    .match_core (req_core),
    .match_addr (DataMem_Address),
    .match      (res_match)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (req_valid) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = (WAIT_STATES == 0) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    if (wait_cnt == WAIT_LAST) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_DONE;
      ST_DONE:    if (!rd_req && !wr_req) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Strobes are registered at acceptance so they are high for exactly the
  // ISSUE cycle. Ready mirrors "next state is DONE", so it can never be
  // observed high while the FSM sits in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      DataMem_Ready <= 1'b0;
      DataMem_In    <= '0;
      SC_Success    <= 1'b0;
      Ram_RE        <= 1'b0;
      Ram_WE        <= '0;
      Ram_Addr      <= '0;
      Ram_WData     <= '0;
      lat_read      <= 1'b0;
      lat_sc_ok     <= 1'b0;
    end else begin
      Ram_RE        <= 1'b0;
      Ram_WE        <= '0;
      DataMem_Ready <= (state_next == ST_DONE);
      if (accept) begin
        Ram_RE    <= is_read;
        Ram_WE    <= do_write ? DataMem_Write : 4'b0000;
        Ram_Addr  <= DataMem_Address;
        Ram_WData <= DataMem_Out;
        lat_read  <= is_read;
        lat_sc_ok <= sc_ok;
      end
      if (state == ST_CAPTURE) begin
        if (lat_read) DataMem_In <= Ram_RData;
        SC_Success <= lat_sc_ok;
      end
    end
  end

endmodule

// File: tb/tb_shared_dmem_ctrl.sv
// tb/tb_shared_dmem_ctrl.sv - directed scoreboard bench for shared_dmem_ctrl
module tb_shared_dmem_ctrl;
  import shared_bus_pkg::*;

  localparam int WS = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_CORES-1:0] D_Bus_GRANT;
  logic                 DataMem_Read;
  logic [3:0]           DataMem_Write;
  logic [ADDR_BITS-1:0] DataMem_Address;
  logic [31:0]          DataMem_Out;
  logic                 DataMem_LL;
  logic                 DataMem_SC;
  logic                 DataMem_Ready;
  logic [31:0]          DataMem_In;
  logic                 SC_Success;
  logic                 Ram_RE;
  logic [3:0]           Ram_WE;
  logic [ADDR_BITS-1:0] Ram_Addr;
  logic [31:0]          Ram_WData;
  logic [31:0]          Ram_RData = '0;

  always #5 clock = ~clock;

  shared_dmem_ctrl #(.WAIT_STATES(WS)) dut (
    .clock           (clock),
    .reset           (reset),
    .D_Bus_GRANT     (D_Bus_GRANT),
    .DataMem_Read    (DataMem_Read),
    .DataMem_Write   (DataMem_Write),
    .DataMem_Address (DataMem_Address),
    .DataMem_Out     (DataMem_Out),
    .DataMem_LL      (DataMem_LL),
    .DataMem_SC      (DataMem_SC),
    .DataMem_Ready   (DataMem_Ready),
    .DataMem_In      (DataMem_In),
    .SC_Success      (SC_Success),
    .Ram_RE          (Ram_RE),
    .Ram_WE          (Ram_WE),
    .Ram_Addr        (Ram_Addr),
    .Ram_WData       (Ram_WData),
    .Ram_RData       (Ram_RData)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 'h10) ? 32'hDEADBEEF : (32'h5A5A0000 | 32'(i));
  endfunction

  // SRAM model: 256 words, registered read data held until the next read.
  logic [31:0] ram [0:255];
  bit          ram_loaded = 1'b0;
  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else begin
      if (Ram_RE) Ram_RData <= ram[Ram_Addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (Ram_WE[b]) ram[Ram_Addr[7:0]][8*b +: 8] <= Ram_WData[8*b +: 8];
    end
  end

  // Strobe monitor, sampled mid-cycle.
  int          we_cnt = 0, re_cnt = 0, ready_cnt = 0;
  logic [3:0]  last_we = '0;
  logic [31:0] last_wdata = '0;
  always @(negedge clock) begin
    if (Ram_WE != 4'b0000) begin
      we_cnt++;
      last_we    = Ram_WE;
      last_wdata = Ram_WData;
    end
    if (Ram_RE) re_cnt++;
    if (DataMem_Ready) ready_cnt++;
  end

  // Reference memory and scoreboard.
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_in = '0;
  typedef struct {
    logic [31:0] din;
    logic        sc;
    logic [3:0]  we;
    bit          rd;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle_bus();
    DataMem_Read  = 1'b0;
    DataMem_Write = 4'b0000;
    DataMem_LL    = 1'b0;
    DataMem_SC    = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [3:0] g, input bit rd, input logic [3:0] wr,
                     input logic [7:0] a, input logic [31:0] d, input bit ll, input bit sc,
                     input bit exp_sc);
    exp_t e;
    int   we0, re0, cyc;
    e.rd  = rd && (wr == 4'b0000);
    e.sc  = exp_sc;
    e.we  = ((wr != 4'b0000) && (!sc || exp_sc)) ? wr : 4'b0000;
    e.din = e.rd ? ref_mem[a] : last_in;
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++)
      if (e.we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    if (e.rd) last_in = e.din;

    @(negedge clock);
    we0 = we_cnt;
    re0 = re_cnt;
    D_Bus_GRANT     = g;
    DataMem_Read    = rd;
    DataMem_Write   = wr;
    DataMem_Address = ADDR_BITS'(a);
    DataMem_Out     = d;
    DataMem_LL      = ll;
    DataMem_SC      = sc;
    cyc = 0;
    while (DataMem_Ready !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    e = exp_q.pop_front();
    chk({tag, " latency"}, 32'(cyc), 32'(3 + WS));
    chk({tag, " rdata"}, DataMem_In, e.din);
    chk({tag, " sc_success"}, 32'(SC_Success), 32'(e.sc));
    chk({tag, " we_pulses"}, 32'(we_cnt - we0), (e.we != 4'b0000) ? 32'd1 : 32'd0);
    chk({tag, " re_pulses"}, 32'(re_cnt - re0), 32'(e.rd));
    if (e.we != 4'b0000) chk({tag, " we_value"}, 32'(last_we), 32'(e.we));
    idle_bus();
    @(negedge clock);
    chk({tag, " ready_drop"}, 32'(DataMem_Ready), 32'd0);
  endtask

  initial begin
    int we0, re0, r0;
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ptr;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset           = 1'b1;
    D_Bus_GRANT     = '0;
    DataMem_Address = '0;
    DataMem_Out     = '0;
    idle_bus();
    #3 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset ready", 32'(DataMem_Ready), 32'd0);
    chk("reset outputs", {DataMem_In[31:8], 1'b0, SC_Success, Ram_RE, Ram_WE, 1'b0},
        32'd0);
    chk("reset ram_addr", 32'(Ram_Addr), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Plain read with wait states.
    txn("t1_read", 4'b0001, 1'b1, 4'b0000, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_value", DataMem_In, 32'hDEADBEEF);

    // Partial write then read-back merge.
    txn("t2_write", 4'b0100, 1'b0, 4'b0011, 8'h20, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0);
    txn("t2_read", 4'b0100, 1'b1, 4'b0000, 8'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_merge", DataMem_In, 32'h5A5ACCDD);
    // Read and write together: write wins.
    txn("rw_both", 4'b0001, 1'b1, 4'b1000, 8'h20, 32'h99000000, 1'b0, 1'b0, 1'b0);
    txn("rw_check", 4'b0001, 1'b1, 4'b0000, 8'h20, 32'h0, 1'b0, 1'b0, 1'b0);

    // LL then SC success, then repeated SC fails.
    txn("t3_ll", 4'b0010, 1'b1, 4'b0000, 8'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    txn("t3_sc_ok", 4'b0010, 1'b0, 4'b1111, 8'h40, 32'h5, 1'b0, 1'b1, 1'b1);
    txn("t3_sc_again", 4'b0010, 1'b0, 4'b1111, 8'h40, 32'h6, 1'b0, 1'b1, 1'b0);
    txn("t3_readback", 4'b0010, 1'b1, 4'b0000, 8'h40, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3_value", DataMem_In, 32'h5);

    // Snoop clear of several reservations by another core's write.
    txn("t4_ll0", 4'b0001, 1'b1, 4'b0000, 8'h80, 32'h0, 1'b1, 1'b0, 1'b0);
    txn("t4_ll2", 4'b0100, 1'b1, 4'b0000, 8'h80, 32'h0, 1'b1, 1'b0, 1'b0);
    txn("t4_wr3", 4'b1000, 1'b0, 4'b1111, 8'h80, 32'h77, 1'b0, 1'b0, 1'b0);
    txn("t4_sc0", 4'b0001, 1'b0, 4'b1111, 8'h80, 32'h1, 1'b0, 1'b1, 1'b0);
    txn("t4_sc2", 4'b0100, 1'b0, 4'b1111, 8'h80, 32'h2, 1'b0, 1'b1, 1'b0);

    // Invalid grants are ignored.
    @(negedge clock);
    we0 = we_cnt; re0 = re_cnt; r0 = ready_cnt;
    D_Bus_GRANT = 4'b0000; DataMem_Read = 1'b1; DataMem_Address = 30'h10;
    repeat (10) @(negedge clock);
    D_Bus_GRANT = 4'b0110; DataMem_Write = 4'b1111;
    repeat (10) @(negedge clock);
    chk("t5_no_re", 32'(re_cnt - re0), 32'd0);
    chk("t5_no_we", 32'(we_cnt - we0), 32'd0);
    chk("t5_no_ready", 32'(ready_cnt - r0), 32'd0);
    idle_bus();

    // Round-robin loop: all four cores request, grants rotate.
    ptr = 0;
    for (int k = 0; k < 8; k++) begin
      txn("t5_rr", 4'(1 << ptr), 1'b0, 4'b1111, 8'(8'h60 + ptr), 32'(ptr), 1'b0, 1'b0, 1'b0);
      chk("t5_rr_order", last_wdata, 32'(exp_order[k]));
      ptr = (ptr + 1) % NUM_CORES;
    end
    txn("t5_rr_read", 4'b0001, 1'b1, 4'b0000, 8'h62, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset in WAIT after a write was issued.
    txn("t6_ll", 4'b0010, 1'b1, 4'b0000, 8'hC0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    D_Bus_GRANT = 4'b0100; DataMem_Write = 4'b1111;
    DataMem_Address = 30'hA0; DataMem_Out = 32'h12345678;
    repeat (2) @(negedge clock);
    ref_mem[8'hA0] = 32'h12345678;
    reset = 1'b0;
    #1;
    chk("t6_ready", 32'(DataMem_Ready), 32'd0);
    chk("t6_data_in", DataMem_In, 32'd0);
    chk("t6_strobes", {26'd0, SC_Success, Ram_RE, Ram_WE}, 32'd0);
    chk("t6_ram_addr", 32'(Ram_Addr), 32'd0);
    chk("t6_ram_wdata", Ram_WData, 32'd0);
    idle_bus();
    last_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    txn("t6_sc_after", 4'b0010, 1'b0, 4'b1111, 8'hC0, 32'h9, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
